// File: rtl/core_req_buffer.sv
// In-order req/gnt decoupling FIFO (DEPTH entries, MAX_OUTSTANDING cap); accept->m_req 1 cycle, rvalid->s_rvalid 1 cycle.
// Backpressure: s_gnt_o drops when FIFO full or cap reached; CORE_REQ_BUFFER_BYPASS_EN adds a 0-cycle path when empty.
module core_req_buffer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  s_req_i,
    output logic                  s_gnt_o,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic                  s_we_i,
    input  logic [3:0]            s_be_i,
    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    output logic                  s_rvalid_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic                  m_req_o,
    input  logic                  m_gnt_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic                  m_we_o,
    output logic [3:0]            m_be_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    input  logic                  m_rvalid_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] MAXO_C  = IW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic                  s_rvalid_q;
    logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;

    entry_t s_entry, m_entry;
    logic   accept, push, pop;

    assign s_entry = '{addr: s_addr_i, we: s_we_i, be: s_be_i, wdata: s_wdata_i};

    // Grant never looks at m_gnt_i: a full FIFO stays closed even on a pop cycle.
    assign s_gnt_o = rst_ni & s_req_i & (count_q < DEPTH_C) & (inflight_q < MAXO_C);
    assign accept  = s_gnt_o;

`ifdef CORE_REQ_BUFFER_BYPASS_EN
    logic bypass;
    assign bypass  = accept & (count_q == '0);
    assign m_req_o = (count_q != '0) | bypass;
    assign m_entry = bypass ? s_entry : mem_q[rd_ptr_q];
    assign push    = accept & ~(bypass & m_gnt_i);
    assign pop     = (count_q != '0) & m_gnt_i;
`else
    assign m_req_o = (count_q != '0);
    assign m_entry = mem_q[rd_ptr_q];
    assign push    = accept;
    assign pop     = m_req_o & m_gnt_i;
`endif

    assign m_addr_o   = m_entry.addr;
    assign m_we_o     = m_entry.we;
    assign m_be_o     = m_entry.be;
    assign m_wdata_o  = m_entry.wdata;
    assign s_rvalid_o = s_rvalid_q;
    assign s_rdata_o  = s_rdata_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        s_rdata_d  = s_rdata_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A stray response at zero in-flight is forwarded but must not underflow the counter.
        if (accept && !m_rvalid_i) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && m_rvalid_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (m_rvalid_i) s_rdata_d = m_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            s_rvalid_q <= 1'b0;
            s_rdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            s_rvalid_q <= m_rvalid_i;
            s_rdata_q  <= s_rdata_d;
            if (push) mem_q[wr_ptr_q] <= s_entry;
        end
    end
endmodule

// File: tb/tb_core_req_buffer.sv
// Directed bench for core_req_buffer with request and response scoreboards.
module tb_core_req_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_req_i, s_gnt_o, s_we_i, s_rvalid_o;
    logic [31:0] s_addr_i, s_wdata_i, s_rdata_o;
    logic [3:0]  s_be_i, m_be_o;
    logic        m_req_o, m_gnt_i, m_we_o, m_rvalid_i;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;

    core_req_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(6)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
        .s_be_i(s_be_i), .s_wdata_i(s_wdata_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rsp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        prev_stall = 1'b0;
    req_t        prev_m, last_m;
    logic        last_gnt, last_mreq;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, sample just after, then advance to the next negedge.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic gnt, input logic rv, input logic [31:0] rd);
        req_t e;
        s_req_i = req; s_addr_i = addr; s_we_i = we; s_be_i = be; s_wdata_i = wd;
        m_gnt_i = gnt; m_rvalid_i = rv; m_rdata_i = rd;
        #2;
        last_gnt  = s_gnt_o;
        last_mreq = m_req_o;
        last_m    = '{addr: m_addr_o, we: m_we_o, be: m_be_o, wdata: m_wdata_o};
        chk("s_rvalid", {79'd0, s_rvalid_o}, {79'd0, exp_rv});
        if (s_rvalid_o === 1'b1 && rsp_q.size() != 0) exp_rdata = rsp_q.pop_front();
        chk("s_rdata", {48'd0, s_rdata_o}, {48'd0, exp_rdata});
        exp_rv = rv;
        if (rv) rsp_q.push_back(rd);
        if (prev_stall) begin
            chk("stall_m_req", {79'd0, m_req_o}, 80'd1);
            chk("stall_m_payload", {11'd0, last_m}, {11'd0, prev_m});
        end
        if (s_req_i && s_gnt_o)
            exp_q.push_back('{addr: addr, we: we, be: be, wdata: wd});
        if (m_req_o && m_gnt_i) begin
            chk("issue_expected", {79'd0, exp_q.size() != 0}, 80'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue_payload", {11'd0, last_m}, {11'd0, e});
            end
        end
        prev_stall = m_req_o && !m_gnt_i;
        prev_m     = last_m;
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; s_req_i = 1'b1; s_addr_i = '0; s_we_i = 1'b0; s_be_i = '0; s_wdata_i = '0;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        @(negedge clk_i); @(negedge clk_i); #2;
        chk("rst_gnt", {79'd0, s_gnt_o}, 80'd0);
        chk("rst_m_req", {79'd0, m_req_o}, 80'd0);
        chk("rst_s_rvalid", {79'd0, s_rvalid_o}, 80'd0);
        chk("rst_s_rdata", {48'd0, s_rdata_o}, 80'd0);
        chk("rst_m_addr", {48'd0, m_addr_o}, 80'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read, grant one cycle later, response two cycles after that.
        cyc(1, 32'h100, 0, 4'hF, 0, 0, 0, 0);
        chk("release_gnt", {79'd0, last_gnt}, 80'd1);
`ifdef CORE_REQ_BUFFER_BYPASS_EN
        chk("rd_m_req_cyc0", {79'd0, last_mreq}, 80'd1);
`else
        chk("rd_m_req_cyc0", {79'd0, last_mreq}, 80'd0);
`endif
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("rd_m_req_cyc1", {79'd0, last_mreq}, 80'd1);
        chk("rd_m_addr_cyc1", {48'd0, last_m.addr}, 80'h100);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_s_rdata_cyc4", {48'd0, s_rdata_o}, 80'hDEADBEEF);

        // FIFO capacity: no downstream grant, five requests.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h300 + 32'(4 * i), 0, 4'hF, 32'(i), 0, 0, 0);
            chk("full_gnt", {79'd0, last_gnt}, {79'd0, i < 4});
        end
        cyc(1, 32'h310, 0, 4'hF, 4, 1, 0, 0);
        chk("full_pop_no_gnt", {79'd0, last_gnt}, 80'd0);
        cyc(1, 32'h310, 0, 4'hF, 4, 0, 0, 0);
        chk("full_gnt_after_pop", {79'd0, last_gnt}, 80'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("full_drained", {79'd0, last_mreq}, 80'd1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 32'h5000 + 32'(i));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("full_queue_empty", {79'd0, last_mreq}, 80'd0);

        // Outstanding cap of 6 with free-running downstream grant.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h400 + 32'(4 * i), 0, 4'hF, 32'(i), 1, 0, 0);
            chk("cap_gnt", {79'd0, last_gnt}, {79'd0, i < 6});
        end
        cyc(1, 32'h480, 0, 4'hF, 0, 1, 1, 32'h6000);
        chk("cap_rv_same_cycle_gnt", {79'd0, last_gnt}, 80'd0);
        cyc(1, 32'h480, 0, 4'hF, 0, 1, 1, 32'h6001);
        chk("cap_gnt_after_rv", {79'd0, last_gnt}, 80'd1);
        cyc(1, 32'h484, 0, 4'hF, 1, 1, 0, 0);
        chk("cap_accept_rv_hold", {79'd0, last_gnt}, 80'd1);
        cyc(1, 32'h488, 0, 4'hF, 2, 1, 0, 0);
        chk("cap_full_again", {79'd0, last_gnt}, 80'd0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 1, 32'h7000 + 32'(i));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Two writes with random downstream stalls (last response above was a stray one).
        for (int w = 0; w < 2; w++) begin
            last_gnt = 1'b0;
            for (int k = 0; k < 20 && !last_gnt; k++)
                cyc(1, w == 0 ? 32'hA0 : 32'hA4, 1, w == 0 ? 4'b0011 : 4'b1100,
                    w == 0 ? 32'h11223344 : 32'h55667788, 0, 0, 0);
            chk("wr_accept", {79'd0, last_gnt}, 80'd1);
        end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++)
            cyc(0, 0, 0, 0, 0, k < 2 ? 1'b0 : 1'($urandom_range(0, 1)), 0, 0);
        chk("wr_drained", 80'(exp_q.size()), 80'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with queued entries, then a late response.
        cyc(1, 32'hB0, 0, 4'hF, 0, 0, 0, 0);
        cyc(1, 32'hB4, 0, 4'hF, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #2;
        chk("midrst_m_req", {79'd0, m_req_o}, 80'd0);
        chk("midrst_gnt", {79'd0, s_gnt_o}, 80'd0);
        chk("midrst_s_rdata", {48'd0, s_rdata_o}, 80'd0);
        exp_q.delete(); rsp_q.delete();
        exp_rv = 1'b0; exp_rdata = '0; prev_stall = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("late_rv_m_req", {79'd0, last_mreq}, 80'd0);

        // Empty buffer, request and grant in the same cycle.
        cyc(1, 32'h200, 0, 4'hF, 0, 1, 0, 0);
        chk("byp_gnt", {79'd0, last_gnt}, 80'd1);
`ifdef CORE_REQ_BUFFER_BYPASS_EN
        chk("byp_m_req_cyc0", {79'd0, last_mreq}, 80'd1);
        chk("byp_m_addr_cyc0", {48'd0, last_m.addr}, 80'h200);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("byp_count_zero", {79'd0, last_mreq}, 80'd0);
`else
        chk("byp_m_req_cyc0", {79'd0, last_mreq}, 80'd0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("byp_m_req_cyc1", {79'd0, last_mreq}, 80'd1);
        chk("byp_m_addr_cyc1", {48'd0, last_m.addr}, 80'h200);
`endif
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("final_empty", 80'(exp_q.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
